// File: rtl/alien_fire_controller.sv
// alien_fire_controller
// Schedules enemy shots for the alien formation. After a frame-counted
// cooldown it picks a start column from a free-running 16-bit Galois LFSR,
// scans one column per cycle for an armed alien (the highest armed row
// index in the column), and issues a req/ack fire request to the enemy
// bullet pool. In-flight enemy bullets are tracked and capped at MAX_BULLETS.
//
// Optional build macro: ALIEN_FIRE_AIM_EN
//   Adds player_x/formation_x inputs and the ALIEN_SPACING_X parameter. When
//   lfsr[8] is set on scan start, the start column aims at the player.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   frame_tick     one-cycle pulse per video frame
//   enable         game running; low freezes firing
//   armed_matrix   bit [r*NUM_COLUMNS+c] set = alien (r,c) armed
//   bullet_done    one-cycle pulse, one enemy bullet retired
//   fire_ack       bullet pool accepts the request this cycle
//   player_x       (ALIEN_FIRE_AIM_EN) player x position
//   formation_x    (ALIEN_FIRE_AIM_EN) left edge of column 0
//   fire_req       fire request
//   fire_row       row index of the firing alien
//   fire_col       column index of the firing alien
//   active_bullets enemy bullets in flight
//   busy           high while selecting or requesting
module alien_fire_controller #(
  parameter int unsigned NUM_ROWS        = 2,
  parameter int unsigned NUM_COLUMNS     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter int unsigned MAX_BULLETS     = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
`ifdef ALIEN_FIRE_AIM_EN
  ,
  parameter int unsigned ALIEN_SPACING_X = 64
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_tick,
  input  logic                                 enable,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0]      armed_matrix,
  input  logic                                 bullet_done,
  input  logic                                 fire_ack,
`ifdef ALIEN_FIRE_AIM_EN
  input  logic [15:0]                          player_x,
  input  logic [15:0]                          formation_x,
`endif
  output logic                                 fire_req,
  output logic [15:0]                          fire_row,
  output logic [15:0]                          fire_col,
  output logic [$clog2(MAX_BULLETS+1)-1:0]     active_bullets,
  output logic                                 busy
);

  localparam int unsigned COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_COLUMNS + 1);
  localparam int unsigned AB_W  = $clog2(MAX_BULLETS + 1);

  localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]      CD_RELOAD = 16'(COOLDOWN_FRAMES);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLUMNS - 1);
  localparam logic [CNT_W-1:0] LAST_SCAN = CNT_W'(NUM_COLUMNS - 1);
  localparam logic [AB_W-1:0]  MAX_AB    = AB_W'(MAX_BULLETS);

  typedef enum logic [1:0] {COOLDOWN, SELECT, REQUEST} state_t;

  state_t           state;
  state_t           state_next;

  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [15:0]      cd_cnt;
  logic [COL_W-1:0] scan_col;
  logic [CNT_W-1:0] scan_cnt;
  logic [ROW_W-1:0] lat_row;
  logic [COL_W-1:0] lat_col;

  logic [NUM_ROWS-1:0] col_bits [NUM_COLUMNS];
  logic [NUM_ROWS-1:0] cur_col;
  logic                col_hit;
  logic [ROW_W-1:0]    hit_row;
  logic                latched_armed;
  logic [COL_W-1:0]    start_col;

  // Control strobes from the next-state process to the datapath.
  logic cd_dec;
  logic cd_retry;
  logic scan_start;
  logic scan_step;
  logic hit_latch;
  logic shot_taken;

  // Regroup the flat matrix by column so a whole column is one lookup.
  for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign col_bits[c][r] = armed_matrix[r*NUM_COLUMNS + c];
    end
  end

  assign lfsr_next     = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign latched_armed = col_bits[lat_col][lat_row];

  // Highest armed row index in the column under scan (lowest alien on screen).
  always_comb begin
    cur_col = col_bits[scan_col];
    col_hit = |cur_col;
    hit_row = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (cur_col[r]) hit_row = ROW_W'(r);
    end
  end

`ifdef ALIEN_FIRE_AIM_EN
  logic [15:0] aim_diff;
  logic [31:0] aim_idx;

  always_comb begin
    aim_diff  = player_x - formation_x;
    aim_idx   = 32'(aim_diff) / ALIEN_SPACING_X;
    start_col = COL_W'(32'(lfsr[7:0]) % NUM_COLUMNS);
    if (lfsr[8]) begin
      if (player_x < formation_x)       start_col = '0;
      else if (aim_idx > NUM_COLUMNS-1) start_col = LAST_COL;
      else                              start_col = COL_W'(aim_idx);
    end
  end
`else
  always_comb begin
    start_col = COL_W'(32'(lfsr[7:0]) % NUM_COLUMNS);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COOLDOWN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cd_dec     = 1'b0;
    cd_retry   = 1'b0;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    hit_latch  = 1'b0;
    shot_taken = 1'b0;
    unique case (state)
      COOLDOWN: begin
        if (enable && frame_tick && cd_cnt != 16'd0) cd_dec = 1'b1;
        if (enable && cd_cnt == 16'd0 && active_bullets < MAX_AB) begin
          state_next = SELECT;
          scan_start = 1'b1;
        end
      end
      SELECT: begin
        // Leaving on enable low keeps cd_cnt (zero here) so firing resumes
        // as soon as enable returns.
        if (!enable) begin
          state_next = COOLDOWN;
        end else if (col_hit) begin
          state_next = REQUEST;
          hit_latch  = 1'b1;
        end else if (scan_cnt == LAST_SCAN) begin
          state_next = COOLDOWN;
          cd_retry   = 1'b1;
        end else begin
          scan_step  = 1'b1;
        end
      end
      REQUEST: begin
        // An ack is honoured even if enable drops or the alien disarms
        // in the same cycle.
        if (fire_ack) begin
          state_next = COOLDOWN;
          shot_taken = 1'b1;
        end else if (!enable) begin
          state_next = COOLDOWN;
        end else if (!latched_armed) begin
          state_next = SELECT;
          scan_start = 1'b1;
        end
      end
      default: state_next = COOLDOWN;
    endcase
  end

  always_comb begin
    fire_req = (state == REQUEST);
    busy     = (state == SELECT) || (state == REQUEST);
    fire_row = 16'(lat_row);
    fire_col = 16'(lat_col);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr           <= SEED;
      cd_cnt         <= CD_RELOAD;
      scan_col       <= '0;
      scan_cnt       <= '0;
      lat_row        <= '0;
      lat_col        <= '0;
      active_bullets <= '0;
    end else begin
      lfsr <= lfsr_next;

      if (cd_dec)          cd_cnt <= cd_cnt - 16'd1;
      else if (cd_retry)   cd_cnt <= 16'd1;
      else if (shot_taken) cd_cnt <= CD_RELOAD;

      if (scan_start) begin
        scan_col <= start_col;
        scan_cnt <= '0;
      end else if (scan_step) begin
        scan_col <= (scan_col == LAST_COL) ? '0 : scan_col + COL_W'(1);
        scan_cnt <= scan_cnt + CNT_W'(1);
      end

      if (hit_latch) begin
        lat_row <= hit_row;
        lat_col <= scan_col;
      end

      // Ack and retire in the same cycle cancel out.
      if (shot_taken && !bullet_done) begin
        if (active_bullets != MAX_AB) active_bullets <= active_bullets + AB_W'(1);
      end else if (!shot_taken && bullet_done && active_bullets != '0) begin
        active_bullets <= active_bullets - AB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alien_fire_controller.sv
// Testbench for alien_fire_controller (default build, COOLDOWN_FRAMES=3).
module tb_alien_fire_controller;

  localparam int NR   = 2;
  localparam int NC   = 4;
  localparam int CDF  = 3;
  localparam int MAXB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        enable;
  logic [7:0]  armed_matrix;
  logic        bullet_done;
  logic        fire_ack;
  logic        fire_req;
  logic [15:0] fire_row;
  logic [15:0] fire_col;
  logic [1:0]  active_bullets;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  alien_fire_controller #(
    .NUM_ROWS       (NR),
    .NUM_COLUMNS    (NC),
    .COOLDOWN_FRAMES(CDF),
    .MAX_BULLETS    (MAXB),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .armed_matrix  (armed_matrix),
    .bullet_done   (bullet_done),
    .fire_ack      (fire_ack),
    .fire_req      (fire_req),
    .fire_row      (fire_row),
    .fire_col      (fire_col),
    .active_bullets(active_bullets),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting out cooldown, 1 = scanning, 2 = requesting.
  // A scan is described by its start column and how many columns it has passed.
  int          m_phase;
  int          m_cd;
  int          m_start;
  int          m_k;
  int          m_row;
  int          m_col;
  int          m_active;
  logic [15:0] m_lfsr;

  function automatic int top_row(input logic [7:0] arm, input int c);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (arm[i*NC + c]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cd = CDF; m_start = 0; m_k = 0;
    m_row = 0; m_col = 0; m_active = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic en, tk, input logic [7:0] arm, input logic bd, ak);
    int n_phase, n_cd, n_start, n_k, n_row, n_col, col, tr;
    bit shot;
    n_phase = m_phase; n_cd = m_cd; n_start = m_start; n_k = m_k;
    n_row = m_row; n_col = m_col; shot = 0;
    case (m_phase)
      0: begin
        if (en && tk && m_cd > 0) n_cd = m_cd - 1;
        if (en && m_cd == 0 && m_active < MAXB) begin
          n_phase = 1; n_start = int'(m_lfsr[7:0]) % NC; n_k = 0;
        end
      end
      1: begin
        col = (m_start + m_k) % NC;
        tr  = top_row(arm, col);
        if (!en) n_phase = 0;
        else if (tr >= 0) begin n_phase = 2; n_row = tr; n_col = col; end
        else if (m_k == NC - 1) begin n_phase = 0; n_cd = 1; end
        else n_k = m_k + 1;
      end
      default: begin
        if (ak) begin shot = 1; n_phase = 0; n_cd = CDF; end
        else if (!en) n_phase = 0;
        else if (!arm[m_row*NC + m_col]) begin
          n_phase = 1; n_start = int'(m_lfsr[7:0]) % NC; n_k = 0;
        end
      end
    endcase
    if (shot && !bd) begin if (m_active < MAXB) m_active = m_active + 1; end
    else if (!shot && bd && m_active > 0) m_active = m_active - 1;
    m_phase = n_phase; m_cd = n_cd; m_start = n_start; m_k = n_k;
    m_row = n_row; m_col = n_col;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  function automatic logic [63:0] pack(input logic rq, bs, input logic [1:0] ac,
                                       input logic [15:0] rw, cl);
    return {28'd0, rq, bs, ac, rw, cl};
  endfunction

  function automatic logic [63:0] dut_pack();
    return pack(fire_req, busy, active_bullets, fire_row, fire_col);
  endfunction

  function automatic logic [63:0] model_pack();
    return pack(m_phase == 2, m_phase != 0, 2'(m_active), 16'(m_row), 16'(m_col));
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, compare after the next rise.
  task automatic step(input logic en, tk, input logic [7:0] arm, input logic bd, ak);
    enable = en; frame_tick = tk; armed_matrix = arm; bullet_done = bd; fire_ack = ak;
    model_step(en, tk, arm, bd, ak);
    @(negedge clk);
    check("model", dut_pack(), model_pack());
  endtask

  task automatic ticks(input int n, input logic en, input logic [7:0] arm);
    for (int i = 0; i < n; i++) begin
      step(en, 1'b1, arm, 1'b0, 1'b0);
      step(en, 1'b0, arm, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_req(input logic [7:0] arm);
    int n;
    n = 0;
    while (!fire_req && n < NC + 2) begin
      step(1'b1, 1'b0, arm, 1'b0, 1'b0);
      n++;
    end
    check("req_wait", fire_req, 1);
  endtask

  typedef struct {
    logic en, tk; logic [7:0] arm; logic bd, ak;
    logic req, bsy; logic [1:0] act; logic [15:0] row, col;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int seen, bc, rq;
    logic ren;
    logic [7:0] rarm;

    // Cycle-by-cycle after reset. The LFSR reaches 16'h1C4E when cooldown
    // expires, so the scan starts at column 0x4E % 4 = 2.
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd1, 16'd2};
    tbl[6]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd1, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1, 16'd2};
    tbl[8]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 16'd1, 16'd2};
    tbl[9]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1, 16'd2};
    tbl[10] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1, 16'd2};

    rst_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; armed_matrix = '0;
    bullet_done = 1'b0; fire_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("reset_state", dut_pack(), 64'd0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].en, tbl[i].tk, tbl[i].arm, tbl[i].bd, tbl[i].ak);
      check($sformatf("tbl%0d", i), dut_pack(),
            pack(tbl[i].req, tbl[i].bsy, tbl[i].act, tbl[i].row, tbl[i].col));
    end

    // Single armed alien (1,2) with the ack withheld.
    ticks(3, 1'b1, 8'h40);
    wait_req(8'h40);
    check("single_row", fire_row, 1);
    check("single_col", fire_col, 2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
    check("hold_stable", {fire_req, fire_row, fire_col}, {1'b1, 16'd1, 16'd2});
    step(1'b1, 1'b0, 8'h40, 1'b0, 1'b1);
    check("ack_drop", fire_req, 0);
    check("ack_count", active_bullets, 1);
    ticks(2, 1'b1, 8'h40);
    check("cd_partial", busy, 0);
    ticks(1, 1'b1, 8'h40);
    check("cd_reload", busy, 1);
    wait_req(8'h40);
    step(1'b1, 1'b0, 8'h40, 1'b0, 1'b1);
    check("two_in_flight", active_bullets, 2);

    // Bullet cap: ack tied high, no shot may start.
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      seen += int'(busy);
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
      seen += int'(busy);
    end
    check("cap_no_shot", seen, 0);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    check("retire_one", active_bullets, 1);
    wait_req(8'hFF);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    check("ack_with_done", active_bullets, 1);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    check("done_at_zero", active_bullets, 0);

    // Empty formation: exactly NC scan cycles, then retry next frame.
    ticks(3, 1'b1, 8'h00);
    bc = int'(busy); rq = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      bc += int'(busy); rq += int'(fire_req);
    end
    check("empty_scan_len", bc, NC);
    check("empty_no_req", rq, 0);
    ticks(1, 1'b1, 8'h08);
    check("retry_frame", busy, 1);
    wait_req(8'h08);
    check("retry_col", fire_col, 3);
    check("retry_row", fire_row, 0);

    // Latched alien disarms mid-request, then enable drops.
    step(1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
    check("disarm_drop", fire_req, 0);
    wait_req(8'h80);
    check("reselect", {fire_row, fire_col}, {16'd1, 16'd3});
    step(1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    check("disable_idle", busy, 0);
    step(1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
    wait_req(8'h80);
    step(1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    ticks(1, 1'b1, 8'h80);
    ticks(5, 1'b0, 8'h80);
    ticks(1, 1'b1, 8'h80);
    check("cd_frozen", busy, 0);
    ticks(1, 1'b1, 8'h80);
    check("cd_resume", busy, 1);

    // Asynchronous reset in the middle of a request.
    wait_req(8'h80);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", fire_req, 0);
    check("rst_active", active_bullets, 0);
    check("rst_busy", busy, 0);
    enable = 1'b0; frame_tick = 1'b0; fire_ack = 1'b0; bullet_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_release", dut_pack(), model_pack());

    // Randomised traffic against the model.
    ren = 1'b1; rarm = 8'hFF;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(29) == 0) ren = ~ren;
      if ($urandom_range(15) == 0) rarm = 8'($urandom);
      step(ren, $urandom_range(3) == 0, rarm, $urandom_range(5) == 0, $urandom_range(2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alien_fire_controller.md
Name: alien_fire_controller

Overview:
Schedules enemy shots for the alien formation. Waits a frame-based cooldown, picks a random starting column with an LFSR, and scans for an armed alien (the lowest alive alien in its column). It then issues a req/ack fire request to the enemy-bullet pool. It tracks in-flight enemy bullets and never exceeds MAX_BULLETS. It sits between alien_formation (armed_matrix) and the enemy bullet logic.

Parameters:
NUM_ROWS, 2, formation rows (≥1)
NUM_COLUMNS, 4, formation columns (≥1)
COOLDOWN_FRAMES, 60, frames between accepted shots (≥1, 16-bit)
MAX_BULLETS, 2, maximum simultaneous enemy bullets (≥1)
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
enable  in  1  game running; low freezes firing
armed_matrix  in  NUM_ROWS*NUM_COLUMNS  bit [r*NUM_COLUMNS+c] set = alien (r,c) armed
bullet_done  in  1  one-cycle pulse: one enemy bullet retired
fire_ack  in  1  bullet pool accepts request this cycle
fire_req  out  1  fire request
fire_row  out  16  row index of the firing alien
fire_col  out  16  column index of the firing alien
active_bullets  out  $clog2(MAX_BULLETS+1)  enemy bullets in flight
busy  out  1  high while in SELECT or REQUEST

Behaviour:
- Reset (async): state=COOLDOWN, cd_cnt=COOLDOWN_FRAMES, lfsr=LFSR_SEED. All outputs are 0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right. It advances every clock out of reset, regardless of state.
- COOLDOWN:
  - On frame_tick with enable=1 and cd_cnt>0, cd_cnt decrements by 1.
  - When cd_cnt==0, enable=1 and active_bullets<MAX_BULLETS, the next state is SELECT.
  - On entering SELECT: scan_col = lfsr[7:0] % NUM_COLUMNS, scan_cnt = 0.
- SELECT: examines one column per cycle.
  - If any bit of column scan_col is armed, latch fire_col=scan_col and fire_row=the highest armed row index in that column, then go to REQUEST.
  - Otherwise scan_col increments, wrapping from NUM_COLUMNS-1 to 0, and scan_cnt increments.
  - After NUM_COLUMNS empty columns, go to COOLDOWN with cd_cnt=1 (retry on the next frame).
  - Worst-case latency from entry to REQUEST: NUM_COLUMNS cycles.
- REQUEST:
  - fire_req=1; fire_row and fire_col stay stable until fire_ack is sampled high.
  - On fire_ack: fire_req drops the next cycle, active_bullets increments, cd_cnt=COOLDOWN_FRAMES, next state is COOLDOWN.
  - If the latched alien's armed bit clears before ack, fire_req drops and the block returns to SELECT from a fresh LFSR column.
  - fire_ack wins over a same-cycle armed clear.
  - fire_ack while fire_req=0 is ignored.
- enable=0:
  - From SELECT or REQUEST (without a same-cycle ack), go to COOLDOWN next cycle; fire_req=0 and cd_cnt is held.
  - In COOLDOWN, cd_cnt does not decrement.
- active_bullets:
  - bullet_done alone decrements it, saturating at 0.
  - fire_ack together with bullet_done leaves it unchanged.
  - It never exceeds MAX_BULLETS.
- busy = (state==SELECT || state==REQUEST).
- Reset mid-REQUEST aborts immediately: fire_req=0, counters reinitialise.

Optional Feature:
ALIEN_FIRE_AIM_EN:
- When defined, adds two inputs: player_x [15:0] and formation_x [15:0] (left edge of column 0). Adds parameter ALIEN_SPACING_X (default 64).
- On SELECT entry with lfsr[8]==1, the start column is the aimed column: (player_x - formation_x) / ALIEN_SPACING_X.
  - Clamped to 0 if player_x < formation_x.
  - Clamped to NUM_COLUMNS-1 if above range.
- With lfsr[8]==0, or when the macro is undefined, the random start column is used. Without the macro these ports and the parameter do not exist.

Test Plan:
- Reset, all armed, COOLDOWN_FRAMES=3, ack tied high: three frame_ticks then fire_req within ≤NUM_COLUMNS+2 cycles; active_bullets=1 after ack.
- Only bit (1,2) armed, fire_ack held low 10 cycles: fire_req stays 1 with fire_row=1 and fire_col=2 stable; ack → req drops next cycle, cd_cnt reloads to 3.
- MAX_BULLETS=2, two shots acked, no bullet_done: no third fire_req across 20 frames; one bullet_done → active_bullets=1, next shot fires after cooldown.
- armed_matrix=0 at cooldown expiry: SELECT scans exactly NUM_COLUMNS cycles, no fire_req, retry on the next frame_tick; arming (0,3) → fire_col=3.
- fire_ack and bullet_done in the same cycle with active_bullets=1 → stays 1; bullet_done at 0 → stays 0.
- During REQUEST, clear the latched armed bit → fire_req drops next cycle; drop enable → COOLDOWN with cd_cnt frozen across 5 frame_ticks.
